// File: rtl/add_issue_queue_pkg.sv
// rtl/add_issue_queue_pkg.sv - shared arithmetic constants and result FSM state type
package add_issue_queue_pkg;

  localparam int unsigned AIQ_WIDTH = 64;
  localparam int unsigned AIQ_DEPTH = 4;
  localparam int unsigned AIQ_TAG_W = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } res_state_e;

endpackage

// File: rtl/operand_fifo.sv
// rtl/operand_fifo.sv - operand pair FIFO feeding the external adder, head presented combinationally
module operand_fifo
  import add_issue_queue_pkg::*;
#(
  parameter int unsigned WIDTH = AIQ_WIDTH,
  parameter int unsigned DEPTH = AIQ_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_flush,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_a,
  input  logic [WIDTH-1:0]        i_b,
  input  logic [AIQ_TAG_W-1:0]    i_tag,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_head_a,
  output logic [WIDTH-1:0]        o_head_b,
  output logic [AIQ_TAG_W-1:0]    o_head_tag,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0]     r_mem_a   [DEPTH];
  logic [WIDTH-1:0]     r_mem_b   [DEPTH];
  logic [AIQ_TAG_W-1:0] r_mem_tag [DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [CW-1:0]        w_count_nxt;
  logic                 w_empty;

  // Storage carries no reset; validity is tracked solely by r_count.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem_a[r_wr_ptr]   <= i_a;
      r_mem_b[r_wr_ptr]   <= i_b;
      r_mem_tag[r_wr_ptr] <= i_tag;
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({i_push, i_pop})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + P_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + P_ONE;
      r_count <= w_count_nxt;
    end
  end

  assign w_empty    = (r_count == '0);
  assign o_full     = (r_count == C_DEPTH);
  assign o_count    = r_count;
  assign o_head_a   = w_empty ? '0 : r_mem_a[r_rd_ptr];
  assign o_head_b   = w_empty ? '0 : r_mem_b[r_rd_ptr];
  assign o_head_tag = w_empty ? '0 : r_mem_tag[r_rd_ptr];

endmodule

// File: rtl/add_issue_queue.sv
// rtl/add_issue_queue.sv - issue queue in front of an external adder with a registered result stage
module add_issue_queue
  import add_issue_queue_pkg::*;
#(
  parameter int unsigned WIDTH = AIQ_WIDTH,
  parameter int unsigned DEPTH = AIQ_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_a,
  input  logic [WIDTH-1:0]        in_b,
  input  logic [AIQ_TAG_W-1:0]    in_tag,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  input  logic [WIDTH:0]          add_s,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH:0]          out_sum,
  output logic [AIQ_TAG_W-1:0]    out_tag,
  output logic [$clog2(DEPTH):0]  count,
  output logic [15:0]             carry_cnt
);

  res_state_e             r_state;
  res_state_e             w_state_nxt;
  logic [WIDTH:0]         r_sum;
  logic [AIQ_TAG_W-1:0]   r_tag;
  logic [15:0]            r_carry_cnt;
  logic [AIQ_TAG_W-1:0]   w_head_tag;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_full;
  logic                   w_push;
  logic                   w_load;
  logic                   w_deliver;

  // in_ready looks only at the current occupancy, so a full queue never accepts even while popping.
  assign in_ready  = !w_full;
  assign w_push    = in_valid && !w_full && !flush;
  assign w_load    = (w_count != '0) && (r_state == ST_EMPTY || out_ready) && !flush;
  assign w_deliver = (r_state == ST_HELD) && out_ready && !flush;

  operand_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_operand_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (flush),
    .i_push     (w_push),
    .i_a        (in_a),
    .i_b        (in_b),
    .i_tag      (in_tag),
    .i_pop      (w_load),
    .o_head_a   (add_a),
    .o_head_b   (add_b),
    .o_head_tag (w_head_tag),
    .o_count    (w_count),
    .o_full     (w_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush)                                   w_state_nxt = ST_EMPTY;
    else if (w_load)                             w_state_nxt = ST_HELD;
    else if (r_state == ST_HELD && out_ready)    w_state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
      r_tag <= '0;
    end else if (flush) begin
      r_sum <= '0;
      r_tag <= '0;
    end else if (w_load) begin
      r_sum <= add_s;
      r_tag <= w_head_tag;
    end
  end

  // Flush leaves the carry statistic alone; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_cnt <= '0;
    end else if (w_deliver && r_sum[WIDTH] && r_carry_cnt != 16'hFFFF) begin
      r_carry_cnt <= r_carry_cnt + 16'd1;
    end
  end

  assign out_valid = (r_state == ST_HELD);
  assign out_sum   = r_sum;
  assign out_tag   = r_tag;
  assign count     = w_count;
  assign carry_cnt = r_carry_cnt;

endmodule
